// File: rtl/hamming_batch_engine.sv
// Batch Hamming encoder/decoder working over a byte-wide data memory, two bytes per message.
// Optional SECDED overall-parity handling (bit 15) is enabled by defining HAMMING_SECDED_EN.
module hamming_batch_engine #(
  parameter int DATA_W = 11,
  parameter int PAR_W  = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              start,
  input  logic              req,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic              busy,
  output logic              halt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);

  localparam int CW_W = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
  localparam bit SECDED = 1'b1;
`else
  localparam bit SECDED = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CALC, WR_LO, WR_HI, DONE} state_t;

  state_t            state_reg;
  logic              mode_reg;
  logic [ADDR_W-1:0] src_ptr_reg;
  logic [ADDR_W-1:0] dst_ptr_reg;
  logic [CNT_W-1:0]  remain_reg;
  logic [7:0]        lo_reg;
  logic [7:0]        hi_out_reg;

  logic [15:0]       in_word;
  logic [CW_W:1]     rx_cw;
  logic [CW_W:1]     data_only;
  logic [CW_W:1]     enc_cw;
  logic [CW_W:1]     fixed_cw;
  logic [DATA_W-1:0] dec_data;
  logic [PAR_W-1:0]  enc_syn;
  logic [PAR_W-1:0]  rx_syn;
  logic              rx_odd;
  logic              in_range;
  logic              flip;
  logic              corr_evt;
  logic              dbl_err;
  logic [15:0]       enc_word;
  logic [15:0]       dec_word;
  logic [15:0]       calc_word;
  logic              unused_bits;

  // In CALC the high byte is arriving on mem_rd_data while the low byte was captured a cycle earlier.
  assign in_word = {mem_rd_data, lo_reg};
  assign rx_cw   = in_word[CW_W-1:0];

  function automatic logic [PAR_W-1:0] syndrome(input logic [CW_W:1] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int p = 1; p <= CW_W; p++) begin
      if (cw[p]) s = s ^ PAR_W'(p);
    end
    return s;
  endfunction

  // Non-power-of-two position p holds data bit p - (number of powers of two <= p) - 1.
  genvar gi;
  generate
    for (gi = 1; gi <= CW_W; gi++) begin : g_pos
      if ((gi & (gi - 1)) == 0) begin : g_par
        assign data_only[gi] = 1'b0;
      end else begin : g_dat
        localparam int DI = gi - $clog2(gi + 1) - 1;
        assign data_only[gi] = in_word[DI];
        assign dec_data[DI]  = fixed_cw[gi];
      end
    end
  endgenerate

  always_comb begin
    enc_syn = syndrome(data_only);
    enc_cw  = data_only;
    for (int j = 0; j < PAR_W; j++) enc_cw[1 << j] = enc_syn[j];
    enc_word     = 16'(enc_cw);
    enc_word[15] = SECDED & (^enc_cw);
  end

  always_comb begin
    rx_syn   = syndrome(rx_cw);
    rx_odd   = SECDED & ((^rx_cw) ^ in_word[15]);
    in_range = (rx_syn != '0) && (int'(rx_syn) <= CW_W);
    if (SECDED) begin
      flip     = rx_odd && in_range;
      corr_evt = rx_odd && ((rx_syn == '0) || in_range);
      dbl_err  = (rx_syn != '0) && !(rx_odd && in_range);
    end else begin
      flip     = in_range;
      corr_evt = in_range;
      dbl_err  = (rx_syn != '0) && !in_range;
    end
    fixed_cw = rx_cw;
    for (int p = 1; p <= CW_W; p++) begin
      if (flip && (int'(rx_syn) == p)) fixed_cw[p] = ~rx_cw[p];
    end
  end

  assign dec_word    = {dbl_err, {(15 - DATA_W){1'b0}}, dec_data};
  assign calc_word   = mode_reg ? dec_word : enc_word;
  assign unused_bits = ^{in_word, fixed_cw};

  always_ff @(posedge CLK) begin
    if (start) begin
      state_reg   <= IDLE;
      mode_reg    <= 1'b0;
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      remain_reg  <= '0;
      lo_reg      <= '0;
      hi_out_reg  <= '0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      halt        <= 1'b0;
      corr_cnt    <= '0;
      dbl_cnt     <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          if (req) begin
            mode_reg    <= mode;
            src_ptr_reg <= src_base;
            dst_ptr_reg <= dst_base;
            remain_reg  <= count;
            corr_cnt    <= '0;
            dbl_cnt     <= '0;
            if (count == '0) begin
              state_reg <= DONE;
              halt      <= 1'b1;
            end else begin
              state_reg <= RD_LO;
              halt      <= 1'b0;
              busy      <= 1'b1;
              mem_addr  <= src_base;
            end
          end
        end
        RD_LO: begin
          mem_addr  <= src_ptr_reg + ADDR_W'(1);
          state_reg <= RD_HI;
        end
        RD_HI: begin
          lo_reg    <= mem_rd_data;
          state_reg <= CALC;
        end
        CALC: begin
          mem_addr    <= dst_ptr_reg;
          mem_wr_en   <= 1'b1;
          mem_wr_data <= calc_word[7:0];
          hi_out_reg  <= calc_word[15:8];
          if (mode_reg && corr_evt && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
          if (mode_reg && dbl_err && (dbl_cnt != '1)) dbl_cnt <= dbl_cnt + CNT_W'(1);
          state_reg <= WR_LO;
        end
        WR_LO: begin
          mem_addr    <= dst_ptr_reg + ADDR_W'(1);
          mem_wr_data <= hi_out_reg;
          state_reg   <= WR_HI;
        end
        WR_HI: begin
          mem_wr_en   <= 1'b0;
          src_ptr_reg <= src_ptr_reg + ADDR_W'(2);
          dst_ptr_reg <= dst_ptr_reg + ADDR_W'(2);
          if (remain_reg == CNT_W'(1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            halt      <= 1'b1;
          end else begin
            remain_reg <= remain_reg - CNT_W'(1);
            mem_addr   <= src_ptr_reg + ADDR_W'(2);
            state_reg  <= RD_LO;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hamming_batch_engine.md
Name: hamming_batch_engine

Overview:
- Parametrised Hamming engine that encodes or decodes a batch of messages stored in the byte-wide data memory.
- One req pulse launches a batch; halt is raised when the batch is done.
- Data width, batch length and base addresses are generalised; encode and decode are runtime modes.
- Sits beside the core as a memory-mapped accelerator on the data_mem port, using the same two-bytes-per-message layout as the existing programs.

Parameters:
- DATA_W, 11, message data bits; legal 1..11.
- PAR_W, 4, Hamming parity bits; must be the smallest P with 2^P >= DATA_W+P+1.
- ADDR_W, 8, data memory address width.
- CNT_W, 8, width of the batch count and the statistics counters.

Ports:
- CLK  in  1  clock.
- start  in  1  synchronous active-high reset.
- req  in  1  one-cycle launch pulse; ignored while busy.
- mode  in  1  0 = encode, 1 = decode; latched on accepted req.
- src_base  in  ADDR_W  first source byte address; latched on req.
- dst_base  in  ADDR_W  first destination byte address; latched on req.
- count  in  CNT_W  number of messages in the batch; latched on req.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rd_data  in  8  read data; valid one cycle after mem_addr.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  8  write data.
- busy  out  1  batch in progress.
- halt  out  1  batch done; held until the next accepted req.
- corr_cnt  out  CNT_W  messages corrected in the last decode batch.
- dbl_cnt  out  CNT_W  messages flagged uncorrectable.

Behaviour:
- Reset values (start=1): busy=0, halt=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, corr_cnt=0, dbl_cnt=0; state IDLE.
- start aborts a running batch at the next edge with no further writes.
- Layout: CW_W = DATA_W+PAR_W. Codeword bit positions run 1..CW_W.
  - Parity bits sit at the power-of-two positions.
  - Data bits d1..dDATA_W fill the remaining positions in ascending order.
  - Position k maps to 16-bit word bit k-1. Message i uses the low byte at base+2i and the high byte at base+2i+1.
  - Unused upper bits are written as 0.
- Encode: source word low DATA_W bits are data; upper source bits are ignored. Parity p_(2^j) = XOR of all data positions whose index has bit j set.
- Decode:
  - Syndrome = XOR of the indices of all set bits in positions 1..CW_W.
  - Syndrome 0: no change.
  - Syndrome 1..CW_W: flip that position, corr_cnt++.
  - Syndrome > CW_W: no flip, dbl_cnt++, output word bit 15 = 1.
  - Output: data right-justified in bits DATA_W-1:0; other bits are 0 except the flag.
- FSM, 5 cycles per message:
  - IDLE: on req, latch inputs, clear the counters, clear halt, go to RD_LO. If count==0, go directly to DONE with no memory access.
  - RD_LO: issue the low address.
  - RD_HI: capture the low byte; issue the high address.
  - CALC: capture the high byte; compute.
  - WR_LO: write the low byte.
  - WR_HI: write the high byte; if this was the last message go to DONE, otherwise RD_LO.
  - DONE: halt=1, busy=0; go to IDLE the same cycle.
- Latency from the accepted req cycle to halt high is 5*count+1 cycles.
- busy is high from the cycle after req until halt.
- A req while busy is ignored. A req coincident with start is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- Counters saturate at all-ones.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- With the macro, encode: word bit 15 = even overall parity over positions 1..CW_W.
- With the macro, decode also computes the overall parity of bit 15 plus positions 1..CW_W:
  - Syndrome!=0 and overall odd: correct as single error, corr_cnt++.
  - Syndrome!=0 and overall even: double error; no flip, bit 15 flag set, dbl_cnt++.
  - Syndrome 0 and overall odd: parity-bit error; data intact, corr_cnt++.
- Without the macro:
  - Encode writes bit 15 as 0; decode ignores bit 15.
  - dbl_cnt counts only syndrome>CW_W cases.

Test Plan:
- Encode: DATA_W=11, mode=0, count=1, src_base=0, dst_base=30, mem[1:0]=0x05,0x55 -> mem[31]=0x55, mem[30]=0x2D; halt rises 6 cycles after req; corr_cnt=0.
- Decode with a single error: mem[65:64]=0x55,0x6D (position 7 flipped), mode=1, src=64, dst=94 -> mem[95:94]=0x05,0x55; corr_cnt=1; dbl_cnt=0.
- DATA_W=4: encode data 0x0B -> word 0x0055; decode 0x0055 -> 0x000B; corr_cnt=0.
- HAMMING_SECDED_EN: decode 0x552E (positions 1 and 2 flipped) -> output 0x8555; dbl_cnt=1; corr_cnt=0.
- count=0 -> halt high 1 cycle after req; no mem_wr_en.
- start asserted during a 15-message batch at message 3 -> no writes after that edge; busy=0, halt=0; the next req runs a clean full batch.
